div_sequencer: RTL

DIV_SEQUENCER -- requirements
Module: div_sequencer

---
 rtl/div_sequencer_pkg.sv | 20 ++
 rtl/div_sequencer.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/div_sequencer_pkg.sv
// Shared definitions for the Euclidean divide sequencer: FSM encoding,
// special-case constants and the magnitude helper.
package div_sequencer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;
   localparam logic [31:0] MIN_INT   = 32'h8000_0000;

   // Magnitude of a two's complement value. MIN_INT is never passed in,
   // because that divisor is resolved without the divider.
   function automatic logic [31:0] abs32(input logic [31:0] a);
      abs32 = a[31] ? (~a + 32'd1) : a;
   endfunction

endpackage

// File: rtl/div_sequencer.sv
// Wraps an external iterative divider so that it produces Euclidean results.
// Zero and MIN_INT divisors are resolved directly, without a divider run.
module div_sequencer
   import div_sequencer_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_x,
   input  logic [31:0] req_y,
   input  logic        abort,
   output logic        div_run,
   input  logic        div_stall,
   output logic [31:0] div_x,
   output logic [31:0] div_y,
   input  logic [31:0] div_quot,
   input  logic [31:0] div_rem,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_quot,
   output logic [31:0] rsp_rem,
   output logic        rsp_div0
);

   state_e      state_q, state_d;
   logic [31:0] div_x_q, div_x_d;
   logic [31:0] div_y_q, div_y_d;
   logic        neg_q, neg_d;
   logic [31:0] quot_q, quot_d;
   logic [31:0] rem_q, rem_d;
   logic        div0_q, div0_d;
   logic        y_zero_s, y_min_s;

   assign y_zero_s = (req_y == 32'd0);
   assign y_min_s  = (req_y == MIN_INT);

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; abort overrides acceptance and capture
   always_comb begin
      state_d = state_q;
      if (abort) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (req_valid) begin
                  state_d = (y_zero_s || y_min_s) ? ST_DONE : ST_RUN;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_RUN: begin
               state_d = div_stall ? ST_RUN : ST_DONE;
            end
            ST_DONE: begin
               state_d = rsp_ready ? ST_IDLE : ST_DONE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // FSM outputs
   always_comb begin
      req_ready = 1'b0;
      div_run   = 1'b0;
      rsp_valid = 1'b0;
      case (state_q)
         ST_IDLE: req_ready = 1'b1;
         ST_RUN:  div_run   = 1'b1;
         ST_DONE: rsp_valid = 1'b1;
         default: req_ready = 1'b0;
      endcase
   end

   // Operand latching and result capture; registers only move on accept or capture
   always_comb begin
      div_x_d = div_x_q;
      div_y_d = div_y_q;
      neg_d   = neg_q;
      quot_d  = quot_q;
      rem_d   = rem_q;
      div0_d  = div0_q;
      if (!abort && state_q == ST_IDLE && req_valid) begin
         if (y_zero_s) begin
            quot_d = DIV0_QUOT;
            rem_d  = req_x;
            div0_d = 1'b1;
         end else if (y_min_s) begin
            // |y| exceeds every dividend magnitude except MIN_INT itself
            quot_d = req_x[31] ? 32'd1 : 32'd0;
            rem_d  = req_x[31] ? (req_x + MIN_INT) : req_x;
            div0_d = 1'b0;
         end else begin
            div_x_d = req_x;
            div_y_d = abs32(req_y);
            neg_d   = req_y[31];
         end
      end else if (!abort && state_q == ST_RUN && !div_stall) begin
         quot_d = neg_q ? (32'd0 - div_quot) : div_quot;
         rem_d  = div_rem;
         div0_d = 1'b0;
      end else begin
         div0_d = div0_q;
      end
   end

   // Datapath registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div_x_q <= 32'd0;
         div_y_q <= 32'd0;
         neg_q   <= 1'b0;
         quot_q  <= 32'd0;
         rem_q   <= 32'd0;
         div0_q  <= 1'b0;
      end else begin
         div_x_q <= div_x_d;
         div_y_q <= div_y_d;
         neg_q   <= neg_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
         div0_q  <= div0_d;
      end
   end

   assign div_x    = div_x_q;
   assign div_y    = div_y_q;
   assign rsp_quot = quot_q;
   assign rsp_rem  = rem_q;
   assign rsp_div0 = div0_q;

endmodule
